intctl: RTL and testbench

- Parametrised interrupt controller. It is the next generation of the fixed 4-bit interrupt encoder.
- It takes NSRC external interrupt sources, each configurable as edge or level and with selectable polarity. Sources are latched, masked and prioritised into an exception code for the CPU.
- It sits on the I/O wishbone segment behind the I/O mmu as a register slave. Its exception output drives the bexkat2 `inter` input.

---
 rtl/intctl_if.sv | 14 +
 rtl/intctl.sv | 130 +++++++++++++
 tb/tb_intctl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/intctl_if.sv
// 32-bit Wishbone register-port bundle shared by intctl and its bus master.
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport slave  (input adr, dat_i, we, sel, cyc, stb, output dat_o, ack);
    modport master (output adr, dat_i, we, sel, cyc, stb, input dat_o, ack);
endinterface

// File: rtl/intctl.sv
// Parametrised interrupt controller: latches, masks and prioritises NSRC sources into a
// CPU exception code. Define INTCTL_SYNC_EN to add a 2-flop synchroniser on irq_in.
module intctl #(
    parameter int          NSRC         = 8,
    parameter int          EXC_W        = 4,
    parameter logic [31:0] RESET_ENABLE = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    if_wb.slave              bus,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             enabled,
    output logic [EXC_W-1:0] cpu_exception,
    output logic             irq_any
);
    typedef enum logic [2:0] {
        REG_PENDING  = 3'd0,
        REG_ENABLE   = 3'd1,
        REG_MODE     = 3'd2,
        REG_POLARITY = 3'd3,
        REG_CURRENT  = 3'd4,
        REG_SWSET    = 3'd5
    } reg_addr_e;

    logic [NSRC-1:0]  pending, enable, mode, polarity, history;
    logic [NSRC-1:0]  irq_s, src, rise, active;
    logic [NSRC-1:0]  wmask, wdata, clear, swset;
    logic [NSRC-1:0]  pending_nxt, enable_nxt, mode_nxt, polarity_nxt;
    logic [31:0]      byte_mask, rdata;
    logic [EXC_W-1:0] code;
    logic [2:0]       addr;
    logic             access, wr;
    logic             unused_ok;

`ifdef INTCTL_SYNC_EN
    logic [NSRC-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end
    assign irq_s = sync_q2;
`else
    assign irq_s = irq_in;
`endif

    // An access is accepted only while ack is low, which forces the one-cycle gap.
    assign access    = bus.cyc & bus.stb & ~bus.ack;
    assign wr        = access & bus.we;
    assign addr      = bus.adr[4:2];
    assign byte_mask = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
    assign wmask     = byte_mask[NSRC-1:0];
    assign wdata     = bus.dat_i[NSRC-1:0] & wmask;
    assign unused_ok = ^{bus.adr[31:5], bus.adr[1:0], bus.dat_i, byte_mask};

    assign src    = irq_s ^ polarity;
    assign rise   = src & ~history;
    assign active = pending & enable;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        enable_nxt   = enable;
        mode_nxt     = mode;
        polarity_nxt = polarity;
        clear        = '0;
        swset        = '0;
        if (wr) begin
            case (addr)
                REG_PENDING:  clear        = wdata;
                REG_ENABLE:   enable_nxt   = (enable & ~wmask) | wdata;
                REG_MODE:     mode_nxt     = (mode & ~wmask) | wdata;
                REG_POLARITY: polarity_nxt = (polarity & ~wmask) | wdata;
                REG_SWSET:    swset        = wdata;
                default:      ;
            endcase
        end
        // Edge bits: set (edge or SWSET) beats W1C; level bits just follow the source.
        pending_nxt = (mode & ((pending & ~clear) | rise | swset)) | (~mode & src);
    end

    always_comb begin
        code = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (active[k]) code = EXC_W'(k + 1);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_PENDING:  rdata = 32'(pending);
            REG_ENABLE:   rdata = 32'(enable);
            REG_MODE:     rdata = 32'(mode);
            REG_POLARITY: rdata = 32'(polarity);
            REG_CURRENT:  rdata = 32'(code);
            default:      rdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending       <= '0;
            enable        <= RESET_ENABLE[NSRC-1:0];
            mode          <= '0;
            polarity      <= '0;
            history       <= '0;
            bus.ack       <= 1'b0;
            bus.dat_o     <= '0;
            cpu_exception <= '0;
            irq_any       <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            enable        <= enable_nxt;
            mode          <= mode_nxt;
            polarity      <= polarity_nxt;
            // History uses the new polarity so a reconfiguration write never looks like an edge.
            history       <= irq_s ^ polarity_nxt;
            bus.ack       <= access;
            bus.dat_o     <= (access && !bus.we) ? rdata : '0;
            cpu_exception <= enabled ? code : '0;
            irq_any       <= |active;
        end
    end
endmodule

// File: tb/tb_intctl.sv
// Bench for intctl: directed scenarios plus randomized traffic, compared every cycle
// against a source-level behavioural model of the controller.
module tb_intctl;
    localparam int          N      = 8;
    localparam int          EW     = 4;
    localparam logic [31:0] RST_EN = 32'h0000_005A;
`ifdef INTCTL_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif
    localparam int LAT_X = SYNC_D + 2;
    localparam logic [2:0] A_PEND = 3'd0, A_EN = 3'd1, A_MODE = 3'd2, A_POL = 3'd3;
    localparam logic [2:0] A_CUR = 3'd4, A_SWSET = 3'd5, A_RSV = 3'd7;

    logic          clk     = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          enabled = 1'b0;
    logic [N-1:0]  irq_in  = '0;
    logic [EW-1:0] cpu_exception;
    logic          irq_any;
    int            errors  = 0;
    int            checks  = 0;
    bit            run_chk = 1'b0;

    if_wb wb();

    intctl #(.NSRC(N), .EXC_W(EW), .RESET_ENABLE(RST_EN)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(wb), .irq_in(irq_in),
        .enabled(enabled), .cpu_exception(cpu_exception), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0]  m_pend, m_en, m_mode, m_pol, m_prev;
    logic [EW-1:0] m_exc;
    logic          m_any, m_ack;
    logic [31:0]   m_rdata;
`ifdef INTCTL_SYNC_EN
    logic [N-1:0]  m_d1, m_d2;
`endif

    function automatic logic [EW-1:0] lowest_code(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return EW'(i + 1);
        return '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            A_PEND:  return 32'(m_pend);
            A_EN:    return 32'(m_en);
            A_MODE:  return 32'(m_mode);
            A_POL:   return 32'(m_pol);
            A_CUR:   return 32'(lowest_code(m_pend & m_en));
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_ni) begin : model
        logic [N-1:0] eff, s, wm, wd, clr, sw, n_en, n_mode, n_pol, n_pend;
        logic         acc;
        if (!rst_ni) begin
            m_pend <= '0; m_en <= RST_EN[N-1:0]; m_mode <= '0; m_pol <= '0; m_prev <= '0;
            m_exc <= '0; m_any <= 1'b0; m_ack <= 1'b0; m_rdata <= '0;
`ifdef INTCTL_SYNC_EN
            m_d1 <= '0; m_d2 <= '0;
`endif
        end else begin
`ifdef INTCTL_SYNC_EN
            eff = m_d2;
            m_d1 <= irq_in;
            m_d2 <= m_d1;
`else
            eff = irq_in;
`endif
            s   = eff ^ m_pol;
            acc = wb.cyc && wb.stb && !m_ack;
            for (int b = 0; b < N; b++) wm[b] = wb.sel[b / 8];
            wd = wb.dat_i[N-1:0] & wm;
            clr = '0; sw = '0; n_en = m_en; n_mode = m_mode; n_pol = m_pol;
            if (acc && wb.we) begin
                case (wb.adr[4:2])
                    A_PEND:  clr = wd;
                    A_EN:    n_en = (m_en & ~wm) | wd;
                    A_MODE:  n_mode = (m_mode & ~wm) | wd;
                    A_POL:   n_pol = (m_pol & ~wm) | wd;
                    A_SWSET: sw = wd;
                    default: ;
                endcase
            end
            for (int k = 0; k < N; k++)
                n_pend[k] = m_mode[k] ? ((s[k] && !m_prev[k]) || sw[k] || (m_pend[k] && !clr[k])) : s[k];
            if (acc && !wb.we) m_rdata <= model_read(wb.adr[4:2]);
            m_exc  <= enabled ? lowest_code(m_pend & m_en) : '0;
            m_any  <= |(m_pend & m_en);
            m_ack  <= acc;
            m_pend <= n_pend; m_en <= n_en; m_mode <= n_mode; m_pol <= n_pol;
            m_prev <= eff ^ n_pol;
        end
    end

    always @(negedge clk) begin
        if (rst_ni && run_chk) begin
            check("exc_model", 32'(cpu_exception), 32'(m_exc));
            check("any_model", 32'(irq_any), 32'(m_any));
            check("ack_model", 32'(wb.ack), 32'(m_ack));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input bit we, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = '0;
        wb.adr = {27'd0, a, 2'b00}; wb.dat_i = d; wb.we = we; wb.sel = sel;
        wb.cyc = 1'b1; wb.stb = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.ack) begin
                got = 1'b1;
                rd  = wb.dat_o;
            end
        end
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        if (got && !we) check("rdata_model", rd, m_rdata);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    initial begin
        logic [31:0] rd;
        wb.adr = '0; wb.dat_i = '0; wb.we = 1'b0; wb.sel = '0; wb.cyc = 1'b0; wb.stb = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk); #1;
        check("rst_exc", 32'(cpu_exception), 32'd0);
        check("rst_any", 32'(irq_any), 32'd0);
        check("rst_ack", 32'(wb.ack), 32'd0);
        rst_ni = 1'b1; run_chk = 1'b1;
        step(1);
        wb_read(A_EN, rd);   check("rst_enable", rd, 32'h5A);
        wb_read(A_PEND, rd); check("rst_pending", rd, 32'd0);

        // Level sources and priority
        wb_write(A_EN, 32'hFF); wb_write(A_MODE, 32'h0); enabled = 1'b1;
        irq_in = 8'h24; step(LAT_X - 1);
        check("lvl_latency", 32'(cpu_exception), 32'd0);
        step(1); check("lvl_both", 32'(cpu_exception), 32'd3);
        irq_in = 8'h20; step(LAT_X); check("lvl_drop2", 32'(cpu_exception), 32'd6);
        irq_in = 8'h00; step(LAT_X); check("lvl_none", 32'(cpu_exception), 32'd0);
        check("lvl_none_any", 32'(irq_any), 32'd0);

        // Edge capture and W1C
        wb_write(A_MODE, 32'h02);
        irq_in = 8'h02; step(1); irq_in = 8'h00; step(LAT_X + 1);
        wb_read(A_PEND, rd); check("edge_pend", rd, 32'h02);
        check("edge_exc", 32'(cpu_exception), 32'd2);
        wb_write(A_PEND, 32'h02);
        wb_read(A_PEND, rd); check("w1c_pend", rd, 32'h0);
        step(1); check("w1c_exc", 32'(cpu_exception), 32'd0);
        irq_in = 8'h02; step(1); irq_in = 8'h00; step(LAT_X + 1);
        irq_in = 8'h02; step(SYNC_D); wb_write(A_PEND, 32'h02);
        wb_read(A_PEND, rd); check("w1c_collide", rd, 32'h02);
        irq_in = 8'h00; step(LAT_X); wb_write(A_PEND, 32'h02);

        // Polarity, edge on a falling input, masking and re-enable
        irq_in = 8'h10; step(LAT_X);
        wb_write(A_EN, 32'hEF); wb_write(A_POL, 32'h10); wb_write(A_MODE, 32'h10);
        wb_read(A_PEND, rd); check("pol_idle", rd, 32'h0);
        irq_in = 8'h00; step(LAT_X + 1);
        wb_read(A_PEND, rd); check("pol_fall", rd, 32'h10);
        check("mask_exc", 32'(cpu_exception), 32'd0);
        check("mask_any", 32'(irq_any), 32'd0);
        wb_write(A_EN, 32'hFF);
        check("reen_before", 32'(cpu_exception), 32'd0);
        step(1); check("reen_exc", 32'(cpu_exception), 32'd5);
        check("reen_any", 32'(irq_any), 32'd1);
        wb_write(A_PEND, 32'h10); wb_write(A_POL, 32'h00); wb_write(A_POL, 32'h10); step(2);
        wb_read(A_PEND, rd); check("reconfig_no_edge", rd, 32'h0);

        // CPU interrupt-enable gate
        wb_write(A_MODE, 32'h0); wb_write(A_POL, 32'h0);
        enabled = 1'b0; irq_in = 8'h01; step(LAT_X);
        check("gate_exc", 32'(cpu_exception), 32'd0);
        check("gate_any", 32'(irq_any), 32'd1);
        enabled = 1'b1; step(1); check("gate_open", 32'(cpu_exception), 32'd1);

        // Reset while ack is high
        wb.adr = {27'd0, A_RSV, 2'b00}; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        step(1);
        check("pre_rst_ack", 32'(wb.ack), 32'd1);
        check("pre_rst_exc", 32'(cpu_exception), 32'd1);
        #2 rst_ni = 1'b0; #1;
        check("rst_async_ack", 32'(wb.ack), 32'd0);
        check("rst_async_exc", 32'(cpu_exception), 32'd0);
        check("rst_async_any", 32'(irq_any), 32'd0);
        check("rst_async_dat", wb.dat_o, 32'd0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(posedge clk); #1; rst_ni = 1'b1; step(1);

        // Reset before a write is acked: the write must not land
        irq_in = 8'h00; step(LAT_X);
        wb.adr = {27'd0, A_EN, 2'b00}; wb.dat_i = 32'hFF; wb.we = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
        #3 rst_ni = 1'b0; #1;
        check("rst_b_ack", 32'(wb.ack), 32'd0);
        @(posedge clk); #1; wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        @(posedge clk); #1; rst_ni = 1'b1; step(1);
        wb_read(A_EN, rd);   check("rst_unacked_write", rd, 32'h5A);
        wb_read(A_PEND, rd); check("rst_pending2", rd, 32'h0);

        // Bus protocol: held strobe, reserved address, SWSET, byte lanes
        wb_write(A_EN, 32'hFF); step(2);
        wb.adr = {27'd0, A_RSV, 2'b00}; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("held_ack", 32'(wb.ack), 32'(i % 2 == 0));
            if (wb.ack) check("held_rdata", wb.dat_o, 32'd0);
        end
        wb.cyc = 1'b0; wb.stb = 1'b0; step(1);
        wb_read(A_RSV, rd); check("rsv_read", rd, 32'd0);
        wb_write(A_MODE, 32'h08); wb_write(A_SWSET, 32'h08);
        wb_read(A_PEND, rd); check("swset_edge", rd, 32'h08);
        wb_read(A_CUR, rd);  check("current", rd, 32'd4);
        wb_write(A_PEND, 32'h08); wb_write(A_MODE, 32'h0); wb_write(A_SWSET, 32'h08);
        wb_read(A_PEND, rd); check("swset_level", rd, 32'h0);
        wb_xfer(1'b1, A_EN, 32'h0000_0000, 4'b1110, rd);
        wb_read(A_EN, rd); check("sel_masked", rd, 32'hFF);
        wb_xfer(1'b1, A_EN, 32'h0000_0033, 4'b0001, rd);
        wb_read(A_EN, rd); check("sel_lane0", rd, 32'h33);

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 600; n++) begin
            irq_in  = 8'($urandom);
            enabled = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0)
                wb_xfer($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom, 4'($urandom), rd);
            else
                step(1);
        end
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
